picorv32_pcpi_arbiter: RTL

PICORV32_PCPI_ARBITER -- requirements
Module: picorv32_pcpi_arbiter

---
 rtl/picorv32_pcpi_arbiter_if.sv | 54 +++++
 rtl/picorv32_pcpi_arbiter.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/picorv32_pcpi_arbiter_if.sv
// PCPI bundle between the core, the arbiter and two coprocessors.
// slave is the arbiter's view; master is the core-plus-coprocessor side.
interface picorv32_pcpi_arbiter_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  pcpi_valid;
    logic [DATA_WIDTH-1:0] pcpi_insn;
    logic [DATA_WIDTH-1:0] pcpi_rs1;
    logic [DATA_WIDTH-1:0] pcpi_rs2;
    logic                  pcpi_wr;
    logic [DATA_WIDTH-1:0] pcpi_rd;
    logic                  pcpi_wait;
    logic                  pcpi_ready;

    logic                  cp0_valid;
    logic [DATA_WIDTH-1:0] cp0_insn;
    logic [DATA_WIDTH-1:0] cp0_rs1;
    logic [DATA_WIDTH-1:0] cp0_rs2;
    logic                  cp0_wr;
    logic [DATA_WIDTH-1:0] cp0_rd;
    logic                  cp0_wait;
    logic                  cp0_ready;

    logic                  cp1_valid;
    logic [DATA_WIDTH-1:0] cp1_insn;
    logic [DATA_WIDTH-1:0] cp1_rs1;
    logic [DATA_WIDTH-1:0] cp1_rs2;
    logic                  cp1_wr;
    logic [DATA_WIDTH-1:0] cp1_rd;
    logic                  cp1_wait;
    logic                  cp1_ready;

    logic [1:0]            grant;

    modport slave (
        input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
        output pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready,
        output cp0_valid, cp0_insn, cp0_rs1, cp0_rs2,
        input  cp0_wr, cp0_rd, cp0_wait, cp0_ready,
        output cp1_valid, cp1_insn, cp1_rs1, cp1_rs2,
        input  cp1_wr, cp1_rd, cp1_wait, cp1_ready,
        output grant
    );

    modport master (
        output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
        input  pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready,
        input  cp0_valid, cp0_insn, cp0_rs1, cp0_rs2,
        output cp0_wr, cp0_rd, cp0_wait, cp0_ready,
        input  cp1_valid, cp1_insn, cp1_rs1, cp1_rs2,
        output cp1_wr, cp1_rd, cp1_wait, cp1_ready,
        input  grant
    );
endinterface

// File: rtl/picorv32_pcpi_arbiter.sv
// Shares one PCPI port between two coprocessors; first claimer (port 0 on ties) owns the insn.
// Latency: 1 cycle valid->cp valid, 1 cycle claim-ready->pcpi_ready; unclaimed insns rejected after TIMEOUT.
module picorv32_pcpi_arbiter #(
    parameter int TIMEOUT    = 32,
    parameter int DATA_WIDTH = 32
) (
    input logic                    clk,
    input logic                    resetn,
    picorv32_pcpi_arbiter_if.slave bus
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, ISSUE, BUSY, RESP, DRAIN, REJECT
    } state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] insn;
        logic [DATA_WIDTH-1:0] rs1;
        logic [DATA_WIDTH-1:0] rs2;
    } req_t;

    state_t                state;
    logic [CW-1:0]         cnt;
    req_t                  req_q;
    logic                  cp0_valid_q;
    logic                  cp1_valid_q;
    logic [1:0]            grant_q;
    logic                  ready_q;
    logic                  wr_q;
    logic                  wait_q;
    logic [DATA_WIDTH-1:0] rd_q;

    // Response of the port that owns the instruction; the other port is never looked at.
    logic                  own_ready;
    logic                  own_wr;
    logic [DATA_WIDTH-1:0] own_rd;

    always_comb begin
        own_ready = 1'b0;
        own_wr    = 1'b0;
        own_rd    = '0;
        if (grant_q[0]) begin
            own_ready = bus.cp0_ready;
            own_wr    = bus.cp0_wr;
            own_rd    = bus.cp0_rd;
        end else if (grant_q[1]) begin
            own_ready = bus.cp1_ready;
            own_wr    = bus.cp1_wr;
            own_rd    = bus.cp1_rd;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            cnt         <= '0;
            req_q       <= '0;
            cp0_valid_q <= 1'b0;
            cp1_valid_q <= 1'b0;
            grant_q     <= 2'b00;
            ready_q     <= 1'b0;
            wr_q        <= 1'b0;
            wait_q      <= 1'b0;
            rd_q        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.pcpi_valid) begin
                        req_q       <= '{insn: bus.pcpi_insn, rs1: bus.pcpi_rs1, rs2: bus.pcpi_rs2};
                        cp0_valid_q <= 1'b1;
                        cp1_valid_q <= 1'b1;
                        cnt         <= '0;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Port 0 is tested first so it wins any same-cycle claim.
                    if (bus.cp0_ready) begin
                        grant_q     <= 2'b01;
                        wr_q        <= bus.cp0_wr;
                        rd_q        <= bus.cp0_rd;
                        ready_q     <= 1'b1;
                        cp0_valid_q <= 1'b0;
                        cp1_valid_q <= 1'b0;
                        state       <= RESP;
                    end else if (bus.cp0_wait) begin
                        grant_q     <= 2'b01;
                        cp1_valid_q <= 1'b0;
                        wait_q      <= 1'b1;
                        state       <= BUSY;
                    end else if (bus.cp1_ready) begin
                        grant_q     <= 2'b10;
                        wr_q        <= bus.cp1_wr;
                        rd_q        <= bus.cp1_rd;
                        ready_q     <= 1'b1;
                        cp0_valid_q <= 1'b0;
                        cp1_valid_q <= 1'b0;
                        state       <= RESP;
                    end else if (bus.cp1_wait) begin
                        grant_q     <= 2'b10;
                        cp0_valid_q <= 1'b0;
                        wait_q      <= 1'b1;
                        state       <= BUSY;
                    end else if (cnt == CNT_LAST) begin
                        cp0_valid_q <= 1'b0;
                        cp1_valid_q <= 1'b0;
                        state       <= REJECT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                BUSY: begin
                    if (own_ready) begin
                        wr_q        <= own_wr;
                        rd_q        <= own_rd;
                        ready_q     <= 1'b1;
                        wait_q      <= 1'b0;
                        cp0_valid_q <= 1'b0;
                        cp1_valid_q <= 1'b0;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    ready_q <= 1'b0;
                    wr_q    <= 1'b0;
                    state   <= DRAIN;
                end
                DRAIN: begin
                    // Core may hold valid past ready; wait for it to drop before re-arming.
                    if (!bus.pcpi_valid) begin
                        grant_q <= 2'b00;
                        state   <= IDLE;
                    end
                end
                REJECT: begin
                    if (!bus.pcpi_valid) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.pcpi_ready = ready_q;
    assign bus.pcpi_wr    = wr_q;
    assign bus.pcpi_rd    = rd_q;
    assign bus.pcpi_wait  = wait_q;
    assign bus.cp0_valid  = cp0_valid_q;
    assign bus.cp0_insn   = req_q.insn;
    assign bus.cp0_rs1    = req_q.rs1;
    assign bus.cp0_rs2    = req_q.rs2;
    assign bus.cp1_valid  = cp1_valid_q;
    assign bus.cp1_insn   = req_q.insn;
    assign bus.cp1_rs1    = req_q.rs1;
    assign bus.cp1_rs2    = req_q.rs2;
    assign bus.grant      = grant_q;
endmodule
